// File: rtl/comparador_seq_ctrl.sv
// Bit-serial three-operand comparator sequencer: scans W bits LSB first through one 1-bit cell.
// Optional early exit on first mismatch is enabled by defining COMPARADOR_EARLY_EXIT_EN.
module comparador_seq_ctrl #(
    parameter int W    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    c,
    output logic            busy,
    output logic            done,
    output logic            diff,
    output logic [IDXW-1:0] first_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1'b1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(W - 1);

    state_t          state_r, state_s;
    logic [W-1:0]    a_r, b_r, c_r;
    logic [IDXW-1:0] idx_r, idx_s;
    logic            diff_r, diff_s;
    logic [IDXW-1:0] first_idx_r, first_idx_s;
    logic            load_s;
    logic            cmp_s;
    logic            busy_r, done_r;

    // The shared comparator cell: 1 when the three bits are not all equal.
    function automatic logic cmp_cell(input logic bit_a, input logic bit_b, input logic bit_c);
        return (bit_a ^ bit_b) | (~bit_a & bit_c) | (bit_b & ~bit_c);
    endfunction

    // Next-state, counter and result update logic.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        diff_s      = diff_r;
        first_idx_s = first_idx_r;
        load_s      = 1'b0;
        cmp_s       = cmp_cell(a_r[idx_r], b_r[idx_r], c_r[idx_r]);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_RUN;
                    load_s      = 1'b1;
                    idx_s       = IDX_ZERO;
                    diff_s      = 1'b0;
                    first_idx_s = IDX_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Only the first mismatch is recorded; later ones leave first_idx alone.
                if (cmp_s && !diff_r) begin
                    diff_s      = 1'b1;
                    first_idx_s = idx_r;
                end else begin
                    diff_s = diff_r;
                end
                if (idx_r == IDX_LAST) begin
                    state_s = ST_DONE;
                end else begin
`ifdef COMPARADOR_EARLY_EXIT_EN
                    if (cmp_s && !diff_r) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
`else
                    idx_s = idx_r + IDX_ONE;
`endif
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand, counter, result and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            c_r         <= {W{1'b0}};
            idx_r       <= IDX_ZERO;
            diff_r      <= 1'b0;
            first_idx_r <= IDX_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            diff_r      <= diff_s;
            first_idx_r <= first_idx_s;
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
            if (load_s) begin
                a_r <= a;
                b_r <= b;
                c_r <= c;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign diff      = diff_r;
    assign first_idx = first_idx_r;

endmodule

// File: tb/tb_comparador_seq_ctrl.sv
// Self-checking bench for comparador_seq_ctrl: directed cases plus randomized operands
// checked against a bit-level reference model of the comparison and its latency.
module tb_comparador_seq_ctrl;

    localparam int W    = 8;
    localparam int IDXW = 3;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W-1:0]    a, b, c;
    logic            busy, done, diff;
    logic [IDXW-1:0] first_idx;

    int tests  = 0;
    int failed = 0;

    comparador_seq_ctrl #(.W(W), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .first_idx (first_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a bit position differs when a^b or a^c is set there.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                         output bit e_diff, output int e_idx, output int e_lat);
        logic [W-1:0] x;
        x      = (ta ^ tb_) | (ta ^ tc);
        e_diff = (x != '0);
        e_idx  = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) e_idx = i;
        end
`ifdef COMPARADOR_EARLY_EXIT_EN
        e_lat = e_diff ? e_idx + 1 : W;
`else
        e_lat = W;
`endif
    endtask

    // Waits for done after the start edge; returns the number of edges taken (0 if none).
    task automatic wait_done(input bit scramble, input int pulse_at, output int lat);
        lat = 0;
        for (int n = 1; n <= W + 4; n++) begin
            @(negedge clk);
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); c = W'($urandom);
            end
            start = (n == pulse_at);
            if (n == pulse_at) begin
                a = ~a; b = W'($urandom); c = W'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] tc, input bit scramble, input int pulse_at);
        bit e_diff; int e_idx; int e_lat; int lat;
        model(ta, tb_, tc, e_diff, e_idx, e_lat);
        @(negedge clk);
        a = ta; b = tb_; c = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        wait_done(scramble, pulse_at, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_diff"}, 32'(diff), 32'(e_diff));
        chk({tag, "_first_idx"}, 32'(first_idx), 32'(e_idx));
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(e_diff));
        chk({tag, "_idx_hold"}, 32'(first_idx), 32'(e_idx));
    endtask

    initial begin
        int lat;
        bit e_diff; int e_idx; int e_lat;
        logic [W-1:0] ra, rb, rc;
        int sel, pos;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_idx", 32'(first_idx), 32'd0);
        @(negedge clk); rst = 1'b0;

        // T1: reset mid-run, no done afterwards
        @(negedge clk);
        a = 8'h00; b = 8'h00; c = 8'h08; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_done", 32'(done), 32'd0);
        chk("t1_diff", 32'(diff), 32'd0);
        chk("t1_idx", 32'(first_idx), 32'd0);
        @(negedge clk); rst = 1'b0;
        lat = 0;
        for (int n = 1; n <= W + 3; n++) begin
            @(posedge clk); #1;
            if (done || busy) lat = n;
        end
        chk("t1_no_done", 32'(lat), 32'd0);

        // T2..T4 directed
        run_op("t2_equal", 8'hA5, 8'hA5, 8'hA5, 1'b0, 0);
        run_op("t3_single", 8'h00, 8'h00, 8'h10, 1'b0, 0);
        run_op("t4_multi", 8'h81, 8'h01, 8'h01, 1'b0, 0);
        run_op("t4_msb", 8'hFF, 8'hFF, 8'h7F, 1'b0, 0);

        // T5: start pulse during run is ignored
        run_op("t5_ignore", 8'h3C, 8'h3C, 8'h3C, 1'b0, 3);
        run_op("t5_ignore2", 8'h00, 8'h40, 8'h00, 1'b0, 2);

        // T5: start held high re-triggers one cycle after done
        model(8'h12, 8'h12, 8'h12, e_diff, e_idx, e_lat);
        @(negedge clk);
        a = 8'h12; b = 8'h12; c = 8'h12; start = 1'b1;
        @(posedge clk); #1;
        wait_done(1'b0, -1, lat);
        @(negedge clk); start = 1'b1;
        chk("t5_hold_lat1", 32'(lat), 32'(e_lat));
        a = 8'h00; b = 8'h04; c = 8'h04;
        @(posedge clk); #1;
        chk("t5_hold_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("t5_hold_rerun", 32'(busy), 32'd1);
        start = 1'b0;
        model(8'h00, 8'h04, 8'h04, e_diff, e_idx, e_lat);
        wait_done(1'b0, -1, lat);
        chk("t5_hold_lat2", 32'(lat), 32'(e_lat));
        chk("t5_hold_diff", 32'(diff), 32'(e_diff));
        chk("t5_hold_idx", 32'(first_idx), 32'(e_idx));
        @(posedge clk); #1;

        // T6: operand isolation with scrambled inputs
        run_op("t6_iso_eq", 8'h5A, 8'h5A, 8'h5A, 1'b1, 0);
        run_op("t6_iso_mm", 8'h00, 8'h20, 8'h00, 1'b1, 0);

        // Randomized: equal operands with optional single/multiple bit perturbations
        for (int t = 0; t < 24; t++) begin
            ra = W'($urandom); rb = ra; rc = ra;
            sel = $urandom_range(0, 3);
            pos = $urandom_range(0, W - 1);
            if (sel == 1) rb[pos] = ~rb[pos];
            else if (sel == 2) rc[pos] = ~rc[pos];
            else if (sel == 3) begin rb = W'($urandom); rc = W'($urandom); end
            run_op("rand", ra, rb, rc, 1'(t % 2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
